evt_logger: RTL and testbench
=============================

# evt_logger

Parametrised successor of the single-entry violation logger for the hw-mod monitor. It takes a vector of `NUM_SRC` violation/reset flags, selects the highest-priority active source, and captures one entry: source code, simultaneous-event flag, PC, per-source address, en and wr bits. Entries are written into an internal circular log RAM, with wrap or stop-on-full behaviour selected by a parameter. The log RAM is read back through a synchronous read port.

## Interface
- `NUM_SRC`, 6: number of event sources; index 0 has the highest priority.
- `CODE_W`, 3: source-code width; requires `2**CODE_W >= NUM_SRC`.
- `PC_W`, 16: PC width.
- `ADDR_W`, 16: per-source address width.
- `DEPTH`, 64: log entries; power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `WRAP`, 1: 1 overwrites the oldest entry when full; 0 stops logging when full.
- `EDGE`, 1: 1 logs on a rising edge of each flag; 0 logs every cycle a flag is high.
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `evt`, in, NUM_SRC: event flags.
- `pc`, in, PC_W: current PC.
- `evt_addr`, in, NUM_SRC*ADDR_W: per-source address; source i uses slice [i*ADDR_W +: ADDR_W].
- `evt_en`, in, NUM_SRC: per-source enable bit.
- `evt_wr`, in, NUM_SRC: per-source write bit.
- `clr`, in, 1: clear the log state. RAM contents are not cleared.
- `rd_en`, in, 1: read request.
- `rd_addr`, in, AW: physical read index.
- `rd_data`, out, ENTRY_W: read data, where `ENTRY_W = CODE_W+1+PC_W+ADDR_W+2`.
- `rd_valid`, out, 1: high when `rd_data` is valid.
- `wr_ptr`, out, AW: next write index.
- `count`, out, AW+1: number of valid entries, saturating at DEPTH.
- `full`, out, 1: `count == DEPTH`.
- `overflow`, out, 1: sticky; set when an entry is overwritten (WRAP=1) or dropped (WRAP=0).
- `drop_cnt`, out, 16: entries dropped while full (WRAP=0), saturating at 16'hFFFF.

## Operation
- Trigger vector:
  - EDGE=1: `trig = evt & ~evt_q`, where `evt_q` is the previous-cycle `evt`.
  - EDGE=0: `trig = evt`.
- Select: lowest set index i of `trig`.
- Entry layout, MSB to LSB: {code=i, multi=(more than one trig bit set), pc, evt_addr slice i, evt_en[i], evt_wr[i]}.
- Lower-priority triggers in the same cycle are not logged. They are only reflected by `multi`.
- Pipeline:
  - Stage C: captures the entry and `cap_v` registers.
  - Stage W: writes RAM[wr_ptr] and updates the pointers.
- Write when `cap_v` is set:
  - Not full: write, `wr_ptr++` (mod DEPTH), `count++`.
  - Full, WRAP=1: write, `wr_ptr++`, `count` stays DEPTH, set `overflow`.
  - Full, WRAP=0: no write, `drop_cnt++` (saturating), set `overflow`.
- `clr`: in the next cycle, `wr_ptr`, `count`, `overflow`, `drop_cnt`, `cap_v` are 0. `evt_q` is loaded normally.
- `clr` with a same-cycle trigger or pending `cap_v`: `clr` wins and both entries are discarded.
- Oldest entry:
  - WRAP=1 and full: index `wr_ptr`.
  - Otherwise: index 0.

## Timing
- Reset values:
  - `rd_data` = 0, `rd_valid` = 0, `wr_ptr` = 0, `count` = 0, `full` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `evt_q` = 0, `cap_v` = 0.
  - With EDGE=1, a flag already high when `rst` deasserts is logged once.
- Logging latency: trigger in cycle t → entry written, and `wr_ptr`/`count` updated, at the clock edge ending cycle t+1.
- Back-to-back triggers in every cycle give one entry per cycle, with no stall.
- Read: `rd_en` in cycle t → `rd_data`/`rd_valid` valid in t+1.
  - `rd_valid` is high exactly for one cycle per request.
  - `rd_data` holds its value when `rd_en` is low.
- Read and write to the same address in the same cycle: the read returns the old contents.
- `rst` mid-pipeline discards the pending `cap_v`. RAM contents are undefined after reset.
- `drop_cnt` at 16'hFFFF stays at 16'hFFFF.
- `wr_ptr` wraps from DEPTH-1 to 0.

## Structure
- Package `logger_pkg`:
  - Field offset/width localparams for the entry layout.
  - The default source-code constants:
    - X_STACK=0, AC=1, ATOMICITY=2, DMA_AC=3, DMA_DETECT=4, DMA_X_STACK=5.
  - A function computing ENTRY_W.
- Sub-module `log_ram`: simple dual-port RAM, with parameters DEPTH and WIDTH.
  - Write port: `we`, `waddr`, `wdata`.
  - Read port: synchronous `re`, `raddr`, `rdata`.
  - Read-first behaviour on a same-address read/write.
- Top level contains: the trigger and priority logic, stage C, the pointer/count/overflow logic, and the `rd_valid` register.

## Test plan
- Reset, then pulse `evt`=6'b000010 at pc=16'h1234, `evt_addr` slice 1=16'hABCD, en=1, wr=1 → two cycles later `count`=1, `wr_ptr`=1; reading index 0 returns code 1, multi 0, pc 16'h1234, addr 16'hABCD, en 1, wr 1.
- `evt`=6'b100100 rising in one cycle → a single entry with code 2, multi=1, and `count` increments by 1.
- EDGE=1, hold `evt[0]` high for 10 cycles → exactly 1 entry. EDGE=0, the same stimulus → 10 entries.
- DEPTH=4, WRAP=1, 6 events with pc 1..6 → `count`=4, `full`=1, `overflow`=1, `wr_ptr`=2; indices 0..3 hold pc 5, 6, 3, 4.
- DEPTH=4, WRAP=0, 6 events → `count`=4, `drop_cnt`=2, indices hold pc 1..4. Then assert `clr` together with a trigger → everything 0 next cycle, and no entry is written.
- Read index k while an entry is being written to index k → returns the old data with `rd_valid`=1; a read of the same index one cycle later returns the new data.

Source files
------------

// File: rtl/evt_logger_pkg.sv
// Shared definitions for the event logger: source codes and entry field layout.
// Entry layout, MSB to LSB: {code, multi, pc, addr, en, wr}.
package logger_pkg;

  typedef enum logic [2:0] {
    X_STACK     = 3'd0,
    AC          = 3'd1,
    ATOMICITY   = 3'd2,
    DMA_AC      = 3'd3,
    DMA_DETECT  = 3'd4,
    DMA_X_STACK = 3'd5
  } src_code_e;

  localparam int unsigned WR_OFF   = 0;
  localparam int unsigned EN_OFF   = 1;
  localparam int unsigned ADDR_OFF = 2;

  function automatic int unsigned pc_off(input int unsigned addr_w);
    return ADDR_OFF + addr_w;
  endfunction

  function automatic int unsigned multi_off(input int unsigned pc_w, input int unsigned addr_w);
    return pc_off(addr_w) + pc_w;
  endfunction

  function automatic int unsigned code_off(input int unsigned pc_w, input int unsigned addr_w);
    return multi_off(pc_w, addr_w) + 1;
  endfunction

  function automatic int unsigned entry_w(input int unsigned code_w, input int unsigned pc_w,
                                          input int unsigned addr_w);
    return code_off(pc_w, addr_w) + code_w;
  endfunction

endpackage

// File: rtl/evt_logger_if.sv
// Event inputs, log status and read-port bundle of the event logger.
interface evt_logger_if #(
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned CODE_W  = 3,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 64
);
  import logger_pkg::*;

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned ENTRY_W = entry_w(CODE_W, PC_W, ADDR_W);

  logic [NUM_SRC-1:0]        evt;
  logic [PC_W-1:0]           pc;
  logic [NUM_SRC*ADDR_W-1:0] evt_addr;
  logic [NUM_SRC-1:0]        evt_en;
  logic [NUM_SRC-1:0]        evt_wr;
  logic                      clr;
  logic                      rd_en;
  logic [AW-1:0]             rd_addr;
  logic [ENTRY_W-1:0]        rd_data;
  logic                      rd_valid;
  logic [AW-1:0]             wr_ptr;
  logic [AW:0]               count;
  logic                      full;
  logic                      overflow;
  logic [15:0]               drop_cnt;

  modport master (
    output evt, pc, evt_addr, evt_en, evt_wr, clr, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_ptr, count, full, overflow, drop_cnt
  );

  modport slave (
    input  evt, pc, evt_addr, evt_en, evt_wr, clr, rd_en, rd_addr,
    output rd_data, rd_valid, wr_ptr, count, full, overflow, drop_cnt
  );

endinterface

// File: rtl/evt_logger_log_ram.sv
// Simple dual-port log RAM with a synchronous, read-first read port.
module log_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Storage is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/evt_logger.sv
// Priority event logger: picks the highest-priority trigger, captures an entry,
// and appends it to a circular log RAM (wrap or stop-on-full).
module evt_logger
  import logger_pkg::*;
#(
  parameter int unsigned NUM_SRC = 6,
  parameter int unsigned CODE_W  = 3,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 64,
  parameter bit          WRAP    = 1'b1,
  parameter bit          EDGE    = 1'b1
) (
  input logic         clk,
  input logic         rst,
  evt_logger_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned ENTRY_W   = entry_w(CODE_W, PC_W, ADDR_W);
  localparam int unsigned PC_OFF    = pc_off(ADDR_W);
  localparam int unsigned MULTI_OFF = multi_off(PC_W, ADDR_W);
  localparam int unsigned CODE_OFF  = code_off(PC_W, ADDR_W);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);

  logic [NUM_SRC-1:0] evt_q;
  logic [NUM_SRC-1:0] trig;
  logic               sel_found;
  logic [ENTRY_W-1:0] entry_d;
  logic [ENTRY_W-1:0] cap_entry;
  logic               cap_v;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count;
  logic               full;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic               we;
  logic               rd_valid;

  assign trig = EDGE ? (bus.evt & ~evt_q) : bus.evt;

  // Lowest set trigger index wins; multi flags any extra trigger bit.
  always_comb begin
    sel_found = 1'b0;
    entry_d   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (trig[i] && !sel_found) begin
        sel_found                    = 1'b1;
        entry_d[CODE_OFF +: CODE_W]  = CODE_W'(i);
        entry_d[ADDR_OFF +: ADDR_W]  = bus.evt_addr[i*ADDR_W +: ADDR_W];
        entry_d[EN_OFF]              = bus.evt_en[i];
        entry_d[WR_OFF]              = bus.evt_wr[i];
      end
    end
    entry_d[MULTI_OFF]       = |(trig & (trig - NUM_SRC'(1)));
    entry_d[PC_OFF +: PC_W]  = bus.pc;
  end

  // Stage C: edge history keeps loading through clr so a held flag is not re-logged.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q     <= '0;
      cap_v     <= 1'b0;
      cap_entry <= '0;
    end else begin
      evt_q     <= bus.evt;
      cap_v     <= (|trig) && !bus.clr;
      cap_entry <= entry_d;
    end
  end

  assign full = (count == FULL_CNT);
  assign we   = cap_v && !bus.clr && (!full || WRAP);

  // Stage W: clr in the same cycle as a pending capture discards it.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (cap_v) begin
      if (!full) begin
        wr_ptr <= wr_ptr + AW'(1);
        count  <= count + (AW+1)'(1);
      end else if (WRAP) begin
        wr_ptr   <= wr_ptr + AW'(1);
        overflow <= 1'b1;
      end else begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= bus.rd_en;
  end

  log_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (cap_entry),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid = rd_valid;
  assign bus.wr_ptr   = wr_ptr;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.overflow = overflow;
  assign bus.drop_cnt = drop_cnt;

endmodule

// File: tb/tb_evt_logger.sv
// Scoreboard bench for evt_logger: three configurations driven in lock-step
// against a queue/arithmetic reference model.
module tb_evt_logger;
  import logger_pkg::*;

  localparam int PCO   = pc_off(16);
  localparam int MULO  = multi_off(16, 16);
  localparam int CODEO = code_off(16, 16);

  function automatic int dep(input int k);     return (k == 0) ? 64 : 4; endfunction
  function automatic bit wrap_of(input int k); return (k != 2);          endfunction
  function automatic bit edge_of(input int k); return (k != 2);          endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_seen = 1'b0;
  int unsigned cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  logic [5:0]  d_evt[3], d_en[3], d_wr[3], d_raddr[3];
  logic [15:0] d_pc[3];
  logic [95:0] d_addr[3];
  logic        d_clr[3], d_rd[3];

  logic [37:0] m_rd[3];
  logic        m_rv[3], m_full[3], m_ovf[3];
  logic [6:0]  m_cnt[3];
  logic [5:0]  m_ptr[3];
  logic [15:0] m_drop[3];

  evt_logger_if #(.DEPTH(64)) if_a ();
  evt_logger_if #(.DEPTH(4))  if_b ();
  evt_logger_if #(.DEPTH(4))  if_c ();

  evt_logger #(.DEPTH(64), .WRAP(1'b1), .EDGE(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  evt_logger #(.DEPTH(4),  .WRAP(1'b1), .EDGE(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  evt_logger #(.DEPTH(4),  .WRAP(1'b0), .EDGE(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  assign if_a.evt = d_evt[0]; assign if_a.pc = d_pc[0]; assign if_a.evt_addr = d_addr[0];
  assign if_a.evt_en = d_en[0]; assign if_a.evt_wr = d_wr[0]; assign if_a.clr = d_clr[0];
  assign if_a.rd_en = d_rd[0]; assign if_a.rd_addr = d_raddr[0];
  assign if_b.evt = d_evt[1]; assign if_b.pc = d_pc[1]; assign if_b.evt_addr = d_addr[1];
  assign if_b.evt_en = d_en[1]; assign if_b.evt_wr = d_wr[1]; assign if_b.clr = d_clr[1];
  assign if_b.rd_en = d_rd[1]; assign if_b.rd_addr = d_raddr[1][1:0];
  assign if_c.evt = d_evt[2]; assign if_c.pc = d_pc[2]; assign if_c.evt_addr = d_addr[2];
  assign if_c.evt_en = d_en[2]; assign if_c.evt_wr = d_wr[2]; assign if_c.clr = d_clr[2];
  assign if_c.rd_en = d_rd[2]; assign if_c.rd_addr = d_raddr[2][1:0];

  assign m_rd[0] = if_a.rd_data; assign m_rv[0] = if_a.rd_valid; assign m_cnt[0] = if_a.count;
  assign m_ptr[0] = if_a.wr_ptr; assign m_full[0] = if_a.full; assign m_ovf[0] = if_a.overflow;
  assign m_drop[0] = if_a.drop_cnt;
  assign m_rd[1] = if_b.rd_data; assign m_rv[1] = if_b.rd_valid; assign m_cnt[1] = 7'(if_b.count);
  assign m_ptr[1] = 6'(if_b.wr_ptr); assign m_full[1] = if_b.full; assign m_ovf[1] = if_b.overflow;
  assign m_drop[1] = if_b.drop_cnt;
  assign m_rd[2] = if_c.rd_data; assign m_rv[2] = if_c.rd_valid; assign m_cnt[2] = 7'(if_c.count);
  assign m_ptr[2] = 6'(if_c.wr_ptr); assign m_full[2] = if_c.full; assign m_ovf[2] = if_c.overflow;
  assign m_drop[2] = if_c.drop_cnt;

  // Reference model: the log is "total entries accepted"; slot = total mod depth.
  logic [37:0] mem[3][64];
  bit          wrt[3][64];
  int unsigned total[3], drop[3];
  bit          ovf[3], pend_v[3];
  logic [37:0] pend[3];
  logic [5:0]  prev[3];

  typedef struct { logic [37:0] d; int unsigned due; } rdexp_t;
  typedef struct {
    int unsigned due; logic [6:0] cnt; logic [5:0] ptr; logic full; logic ovf; logic [15:0] drop;
  } st_t;
  rdexp_t rdq[3][$];
  st_t    stq[3][$];
  logic [37:0] last_exp[3];

  int unsigned n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc=%0d got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_cycle(input int k);
    int unsigned D = dep(k);
    logic [5:0] trig;
    int sel;
    st_t s;
    rdexp_t r;
    if (rst) begin
      total[k] = 0; drop[k] = 0; ovf[k] = 0; pend_v[k] = 0; prev[k] = '0;
      for (int i = 0; i < 64; i++) wrt[k][i] = 0;
    end else begin
      if (d_rd[k]) begin
        r.d = mem[k][d_raddr[k]]; r.due = cyc + 1; rdq[k].push_back(r);
      end
      if (pend_v[k] && !d_clr[k]) begin
        if (total[k] < D || wrap_of(k)) begin
          if (total[k] >= D) ovf[k] = 1;
          mem[k][total[k] % D] = pend[k];
          wrt[k][total[k] % D] = 1;
          total[k]++;
        end else begin
          ovf[k] = 1;
          if (drop[k] < 65535) drop[k]++;
        end
      end
      if (d_clr[k]) begin total[k] = 0; drop[k] = 0; ovf[k] = 0; end
      trig = edge_of(k) ? (d_evt[k] & ~prev[k]) : d_evt[k];
      prev[k] = d_evt[k];
      pend_v[k] = 0;
      if (!d_clr[k] && trig != 0) begin
        sel = 0;
        while (!trig[sel]) sel++;
        pend[k] = {3'(sel), ($countones(trig) > 1), d_pc[k], d_addr[k][sel*16 +: 16],
                   d_en[k][sel], d_wr[k][sel]};
        pend_v[k] = 1;
      end
    end
    s.due  = cyc + 1;
    s.cnt  = 7'((total[k] < D) ? total[k] : D);
    s.ptr  = 6'(total[k] % D);
    s.full = (total[k] >= D);
    s.ovf  = ovf[k];
    s.drop = 16'(drop[k]);
    stq[k].push_back(s);
  endtask

  task automatic step();
    for (int k = 0; k < 3; k++) model_cycle(k);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    st_t s;
    rdexp_t r;
    for (int k = 0; k < 3; k++) begin
      if (rst_seen) last_exp[k] = '0;
      if (stq[k].size() > 0 && stq[k][0].due == cyc) begin
        s = stq[k].pop_front();
        chk("count", k, 64'(m_cnt[k]), 64'(s.cnt));
        chk("wr_ptr", k, 64'(m_ptr[k]), 64'(s.ptr));
        chk("full", k, 64'(m_full[k]), 64'(s.full));
        chk("overflow", k, 64'(m_ovf[k]), 64'(s.ovf));
        chk("drop_cnt", k, 64'(m_drop[k]), 64'(s.drop));
      end
      if (m_rv[k]) begin
        if (rdq[k].size() == 0) chk("rd_valid_spurious", k, 64'(1), 64'(0));
        else begin
          r = rdq[k].pop_front();
          chk("rd_latency", k, 64'(cyc), 64'(r.due));
          chk("rd_data", k, 64'(m_rd[k]), 64'(r.d));
          last_exp[k] = r.d;
        end
      end else begin
        if (rdq[k].size() > 0 && rdq[k][0].due <= cyc) begin
          r = rdq[k].pop_front();
          chk("rd_valid_missing", k, 64'(0), 64'(1));
        end
        chk("rd_hold", k, 64'(m_rd[k]), 64'(last_exp[k]));
      end
    end
  end

  function automatic logic [15:0] exp_pc_b(input int idx);
    return 16'((idx < 2) ? idx + 5 : idx + 1);
  endfunction

  initial begin
    logic [37:0] e1;
    for (int k = 0; k < 3; k++) begin
      d_evt[k] = '0; d_en[k] = '0; d_wr[k] = '0; d_raddr[k] = '0; d_pc[k] = '0;
      d_addr[k] = '0; d_clr[k] = 0; d_rd[k] = 0; last_exp[k] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rd_valid", k, 64'(m_rv[k]), 64'(0));
      chk("rst_rd_data", k, 64'(m_rd[k]), 64'(0));
      chk("rst_count", k, 64'(m_cnt[k]), 64'(0));
    end

    // Single pulse on source 1.
    d_evt[0] = 6'b000010; d_pc[0] = 16'h1234; d_addr[0][16 +: 16] = 16'hABCD;
    d_en[0] = 6'b000010; d_wr[0] = 6'b000010;
    step();
    d_evt[0] = '0;
    step();
    chk("t1_count", 0, 64'(m_cnt[0]), 64'(1));
    chk("t1_wr_ptr", 0, 64'(m_ptr[0]), 64'(1));
    d_rd[0] = 1; d_raddr[0] = 6'd0;
    step();
    d_rd[0] = 0;
    e1 = {3'(AC), 1'b0, 16'h1234, 16'hABCD, 1'b1, 1'b1};
    chk("t1_entry", 0, 64'(m_rd[0]), 64'(e1));

    // Simultaneous rise of sources 2 and 5.
    d_evt[0] = 6'b100100; d_en[0] = 6'($urandom); d_wr[0] = 6'($urandom);
    step();
    d_evt[0] = '0;
    step();
    chk("t2_count", 0, 64'(m_cnt[0]), 64'(2));
    d_rd[0] = 1; d_raddr[0] = 6'd1;
    step();
    d_rd[0] = 0;
    chk("t2_code", 0, 64'(m_rd[0][CODEO +: 3]), 64'(ATOMICITY));
    chk("t2_multi", 0, 64'(m_rd[0][MULO]), 64'(1));

    // Held flag with EDGE=1 logs once.
    d_evt[0] = 6'b000001;
    repeat (10) step();
    d_evt[0] = '0;
    repeat (2) step();
    chk("hold_edge_count", 0, 64'(m_cnt[0]), 64'(3));

    // Six back-to-back events into the depth-4 instances.
    for (int i = 1; i <= 6; i++) begin
      d_evt[1] = 6'(1 << (i - 1)); d_evt[2] = 6'(1 << (i - 1));
      d_pc[1] = 16'(i); d_pc[2] = 16'(i);
      step();
    end
    d_evt[1] = '0; d_evt[2] = '0;
    repeat (2) step();
    chk("wrap_count", 1, 64'(m_cnt[1]), 64'(4));
    chk("wrap_full", 1, 64'(m_full[1]), 64'(1));
    chk("wrap_ovf", 1, 64'(m_ovf[1]), 64'(1));
    chk("wrap_ptr", 1, 64'(m_ptr[1]), 64'(2));
    chk("stop_count", 2, 64'(m_cnt[2]), 64'(4));
    chk("stop_drop", 2, 64'(m_drop[2]), 64'(2));
    for (int idx = 0; idx < 4; idx++) begin
      d_rd[1] = 1; d_rd[2] = 1; d_raddr[1] = 6'(idx); d_raddr[2] = 6'(idx);
      step();
      chk("wrap_pc", 1, 64'(m_rd[1][PCO +: 16]), 64'(exp_pc_b(idx)));
      chk("stop_pc", 2, 64'(m_rd[2][PCO +: 16]), 64'(idx + 1));
    end
    d_rd[1] = 0; d_rd[2] = 0;

    // Read of the slot being overwritten returns the old entry first.
    d_evt[1] = 6'b000001; d_pc[1] = 16'h0077;
    step();
    d_evt[1] = '0; d_rd[1] = 1; d_raddr[1] = 6'd2;
    step();
    chk("rw_old", 1, 64'(m_rd[1][PCO +: 16]), 64'(3));
    step();
    chk("rw_new", 1, 64'(m_rd[1][PCO +: 16]), 64'(16'h0077));
    d_rd[1] = 0;

    // clr beats both a pending capture and a same-cycle trigger.
    d_evt[2] = 6'b000001;
    step();
    d_clr[2] = 1;
    step();
    chk("clr_count", 2, 64'(m_cnt[2]), 64'(0));
    chk("clr_drop", 2, 64'(m_drop[2]), 64'(0));
    chk("clr_ovf", 2, 64'(m_ovf[2]), 64'(0));
    chk("clr_ptr", 2, 64'(m_ptr[2]), 64'(0));
    d_clr[2] = 0; d_evt[2] = '0;
    step();
    chk("clr_after", 2, 64'(m_cnt[2]), 64'(0));

    // Held flag with EDGE=0 logs every cycle.
    d_evt[2] = 6'b000001;
    repeat (10) step();
    d_evt[2] = '0;
    repeat (2) step();
    chk("hold_level_count", 2, 64'(m_cnt[2]), 64'(4));
    chk("hold_level_drop", 2, 64'(m_drop[2]), 64'(6));

    // Random traffic with one mid-run reset.
    for (int n = 0; n < 400; n++) begin
      rst = (n >= 200 && n < 202);
      for (int k = 0; k < 3; k++) begin
        int idx;
        d_evt[k]  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom & (n % 2 == 0 ? 1 : 0));
        d_pc[k]   = 16'($urandom);
        d_addr[k] = {$urandom, $urandom, $urandom};
        d_en[k]   = 6'($urandom);
        d_wr[k]   = 6'($urandom);
        d_clr[k]  = ($urandom_range(0, 39) == 0);
        idx = $urandom_range(0, dep(k) - 1);
        d_rd[k]   = !rst && wrt[k][idx] && ($urandom_range(0, 2) == 0);
        d_raddr[k] = 6'(idx);
      end
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d_evt[k] = '0; d_clr[k] = 0; d_rd[k] = 0;
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) chk("rdq_drained", k, 64'(rdq[k].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
